// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue/writeback controller: datapath sizes,
// op codes, op legality and the controller state encoding.
package alu_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int REG_AW   = $clog2(NUM_REGS);
    localparam int IMM_W    = 8;
    localparam int OP_W     = 4;

    localparam logic [OP_W-1:0] OP_ADD = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB = 4'd1;
    localparam logic [OP_W-1:0] OP_AND = 4'd2;
    localparam logic [OP_W-1:0] OP_OR  = 4'd3;
    localparam logic [OP_W-1:0] OP_NOT = 4'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

    // Instruction register contents, latched on accept and held while busy.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              imm_en;
        logic [IMM_W-1:0]  imm;
    } instr_t;

    // Codes above OP_NOT are retired as illegal without a register write.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return op <= OP_NOT;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x16 register file: two combinational operand read ports, one debug read
// port, one synchronous write port. r0 is hardwired to zero.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [REG_AW-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [REG_AW-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    // Register array: cleared on reset, written at the end of a writeback cycle.
    always_ff @(posedge clk) begin
        // NOTE: this array is cleared on reset because software relies on all
        // registers reading 0 after reset; it is a small flop array, not a RAM
        // macro. Sequential state uses non-blocking assignments only.
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs_q[waddr] <= wdata;
        end
    end

    // r0 reads as zero regardless of array contents.
    assign rdata_a  = (raddr_a  == '0) ? '0 : regs_q[raddr_a];
    assign rdata_b  = (raddr_b  == '0) ? '0 : regs_q[raddr_b];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue and writeback controller for the 16-bit ALU. Accepts one instruction
// over valid/ready, spends one cycle in EXEC driving the ALU and one cycle in
// WB committing the result, overlapping the next accept with WB.
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [OP_W-1:0]   instr_op,
    input  logic [REG_AW-1:0] instr_rd,
    input  logic [REG_AW-1:0] instr_rs,
    input  logic [REG_AW-1:0] instr_rt,
    input  logic              instr_imm_en,
    input  logic [IMM_W-1:0]  instr_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_out,
    output logic              wb_valid,
    output logic [REG_AW-1:0] wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              err_illegal,
    output logic              busy,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_e            state_q, state_d;
    instr_t            instr_q, instr_d;
    instr_t            instr_in;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] rdata_a, rdata_b;
    logic              accept;
    logic              in_exec;
    logic              in_wb;
    logic              op_legal;

    assign instr_in = '{
        op:     instr_op,
        rd:     instr_rd,
        rs:     instr_rs,
        rt:     instr_rt,
        imm_en: instr_imm_en,
        imm:    instr_imm
    };

    // Reset blocks the handshake so a coincident instruction is never taken.
    assign instr_ready = (state_q != EXEC) && !reset;
    assign accept      = instr_valid && instr_ready;
    assign in_exec     = (state_q == EXEC);
    assign in_wb       = (state_q == WB) && !reset;
    assign op_legal    = is_legal_op(instr_q.op);
    assign busy        = (state_q == EXEC) || (state_q == WB);

    // ALU operands are only meaningful in EXEC; hold them at zero otherwise.
    assign alu_op = in_exec ? instr_q.op : '0;
    assign alu_a  = in_exec ? rdata_a : '0;
    assign alu_b  = !in_exec      ? '0 :
                    instr_q.imm_en ? {{(DATA_W-IMM_W){1'b0}}, instr_q.imm} :
                                     rdata_b;

    assign wb_valid    = in_wb && op_legal;
    assign err_illegal = in_wb && !op_legal;
    assign wb_rd       = wb_valid ? instr_q.rd : '0;
    assign wb_data     = wb_valid ? result_q : '0;

    alu_regfile u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we       (wb_valid),
        .waddr    (instr_q.rd),
        .wdata    (result_q),
        .raddr_a  (instr_q.rs),
        .rdata_a  (rdata_a),
        .raddr_b  (instr_q.rt),
        .rdata_b  (rdata_b),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Next-state logic: IDLE -> EXEC on accept, EXEC -> WB, WB -> EXEC/IDLE.
    always_comb begin
        // NOTE: every variable gets its hold value first so that no path
        // through the case leaves it unassigned, which would infer a latch.
        state_d  = state_q;
        instr_d  = instr_q;
        result_d = result_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    instr_d = instr_in;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                result_d = alu_out;
                state_d  = WB;
            end
            WB: begin
                if (accept) begin
                    instr_d = instr_in;
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, instruction and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            instr_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl. A transaction-level model tracks
// each accepted instruction by the cycle it executes in and checks every
// output on every cycle; directed tests pin the model with literal values.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_op;
    logic [2:0]  instr_rd, instr_rs, instr_rt;
    logic        instr_imm_en;
    logic [7:0]  instr_imm;
    logic [15:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_op;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [15:0] wb_data;
    logic        err_illegal;
    logic        busy;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_rd     (instr_rd),
        .instr_rs     (instr_rs),
        .instr_rt     (instr_rt),
        .instr_imm_en (instr_imm_en),
        .instr_imm    (instr_imm),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_out      (alu_out),
        .wb_valid     (wb_valid),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .err_illegal  (err_illegal),
        .busy         (busy),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    // Behavioural 16-bit ALU attached to the controller.
    function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return ~a;
            default: return 16'hDEAD;
        endcase
    endfunction

    assign alu_out = alu_f(alu_op, alu_a, alu_b);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         exec_cyc;
        logic [3:0] op;
        logic [2:0] rd, rs, rt;
        logic       imm_en;
        logic [7:0] imm;
    } rec_t;

    rec_t        q[$];
    logic [15:0] m_regs [8] = '{default: 16'h0};
    int          cyc      = 0;
    bit          model_ok = 0;

    function automatic logic [15:0] m_rd(input logic [2:0] a);
        return (a == 3'd0) ? 16'h0 : m_regs[a];
    endfunction

    function automatic bit find_rec(input int c, output rec_t r);
        r = '{default: 0};
        foreach (q[i]) if (q[i].exec_cyc == c) begin
            r = q[i];
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [15:0] m_result(input rec_t r);
        return alu_f(r.op, m_rd(r.rs), r.imm_en ? {8'h00, r.imm} : m_rd(r.rt));
    endfunction

    // Model update: an instruction accepted at an edge executes in the next
    // cycle and commits in the one after; one may be accepted while another commits.
    always @(posedge clk) begin
        rec_t w, e, n;
        int   k;
        k = cyc;
        if (reset) begin
            q.delete();
            m_regs   = '{default: 16'h0};
            model_ok = 1;
        end else begin
            if (find_rec(k - 1, w) && w.op <= 4'd4 && w.rd != 3'd0)
                m_regs[w.rd] = m_result(w);
            if (instr_valid && !find_rec(k, e)) begin
                n = '{exec_cyc: k + 1, op: instr_op, rd: instr_rd, rs: instr_rs,
                      rt: instr_rt, imm_en: instr_imm_en, imm: instr_imm};
                q.push_back(n);
            end
            while (q.size() > 0 && q[0].exec_cyc < k) void'(q.pop_front());
        end
        cyc = k + 1;
    end

    // Per-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        rec_t e, w;
        bit   he, hw, legal;
        if (model_ok) begin
            he    = find_rec(cyc, e);
            hw    = find_rec(cyc - 1, w);
            legal = hw && (w.op <= 4'd4) && !reset;
            check("instr_ready", instr_ready, !reset && !he);
            check("busy",        busy,        he || hw);
            check("alu_op",      alu_op,      he ? e.op : 4'h0);
            check("alu_a",       alu_a,       he ? m_rd(e.rs) : 16'h0);
            check("alu_b",       alu_b,       !he ? 16'h0 : e.imm_en ? {8'h00, e.imm} : m_rd(e.rt));
            check("wb_valid",    wb_valid,    legal);
            check("wb_rd",       wb_rd,       legal ? w.rd : 3'd0);
            check("wb_data",     wb_data,     legal ? m_result(w) : 16'h0);
            check("err_illegal", err_illegal, hw && !reset && (w.op > 4'd4));
            check("dbg_data",    dbg_data,    m_rd(dbg_addr));
        end
    end

    // ---------------- writeback log for literal checks ----------------
    typedef struct {
        int          c;
        logic [2:0]  rd;
        logic [15:0] data;
    } wb_t;

    wb_t wb_log[$];
    int  err_cnt = 0;

    always @(negedge clk) begin
        wb_t x;
        if (!reset && wb_valid === 1'b1) begin
            x = '{c: cyc, rd: wb_rd, data: wb_data};
            wb_log.push_back(x);
        end
        if (!reset && err_illegal === 1'b1) err_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic imm_en, input logic [7:0] imm,
                         input bit hold, output int acc_cyc);
        bit got, r;
        got          = 0;
        instr_valid  = 1'b1;
        instr_op     = op;
        instr_rd     = rd;
        instr_rs     = rs;
        instr_rt     = rt;
        instr_imm_en = imm_en;
        instr_imm    = imm;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            r = (instr_ready === 1'b1);
            @(posedge clk);
            if (r) got = 1;
        end
        #1;
        if (!hold) instr_valid = 1'b0;
        acc_cyc = cyc;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: instruction op=%0d rd=%0d not accepted within 20 cycles", op, rd);
        end
    endtask

    task automatic drain();
        repeat (3) begin
            @(posedge clk);
            #1 dbg_addr = dbg_addr + 3'd1;
        end
    endtask

    task automatic peek(input logic [2:0] a, input logic [15:0] exp, input string name);
        dbg_addr = a;
        #1;
        check(name, dbg_data, exp);
    endtask

    initial begin
        int a3, rc, acc2;
        int hold_acc[5];

        // Reset for two cycles with a competing instruction that must be ignored.
        reset        = 1'b1;
        instr_valid  = 1'b1;
        instr_op     = 4'd0;
        instr_rd     = 3'd1;
        instr_rs     = 3'd0;
        instr_rt     = 3'd0;
        instr_imm_en = 1'b1;
        instr_imm    = 8'hFF;
        dbg_addr     = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        reset       = 1'b0;
        instr_valid = 1'b0;
        @(negedge clk);
        check("rst_ready",    instr_ready, 1'b1);
        check("rst_busy",     busy,        1'b0);
        check("rst_wb_valid", wb_valid,    1'b0);
        check("rst_err",      err_illegal, 1'b0);
        for (int i = 0; i < 8; i++) peek(i[2:0], 16'h0, "rst_dbg");

        // Immediate loads and a register ADD.
        issue(4'd0, 3'd1, 3'd0, 3'd0, 1'b1, 8'h05, 0, rc);
        issue(4'd0, 3'd2, 3'd0, 3'd0, 1'b1, 8'h07, 0, rc);
        issue(4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 0, a3);
        check("add_exec_a",  alu_a,  16'h0005);
        check("add_exec_b",  alu_b,  16'h0007);
        check("add_exec_op", alu_op, 4'd0);
        drain();
        check("log_n1",  wb_log.size(), 3);
        check("ld_r1",   wb_log[0].data, 16'h0005);
        check("ld_r2",   wb_log[1].data, 16'h0007);
        check("add_r3",  wb_log[2].data, 16'h000C);
        check("add_rd",  wb_log[2].rd,   3'd3);
        check("add_lat", wb_log[2].c,    a3 + 1);

        // Wrap-around subtraction and logic ops.
        issue(4'd1, 3'd4, 3'd0, 3'd1, 1'b0, 8'h00, 0, rc);
        issue(4'd4, 3'd5, 3'd0, 3'd0, 1'b0, 8'h00, 0, rc);
        issue(4'd2, 3'd6, 3'd5, 3'd0, 1'b1, 8'hA5, 0, rc);
        issue(4'd3, 3'd6, 3'd6, 3'd1, 1'b0, 8'h00, 0, rc);
        drain();
        check("log_n2",  wb_log.size(), 7);
        check("sub_r4",  wb_log[3].data, 16'hFFFB);
        check("not_r5",  wb_log[4].data, 16'hFFFF);
        check("and_r6",  wb_log[5].data, 16'h00A5);
        check("or_r6",   wb_log[6].data, 16'h00A5);
        peek(3'd4, 16'hFFFB, "dbg_r4");

        // Back-to-back dependent increments with instr_valid held high.
        for (int i = 0; i < 5; i++) issue(4'd0, 3'd1, 3'd1, 3'd0, 1'b1, 8'h01, 1, hold_acc[i]);
        instr_valid = 1'b0;
        drain();
        check("log_n3", wb_log.size(), 12);
        for (int i = 0; i < 5; i++) check("b2b_data", wb_log[7+i].data, 16'h0006 + 16'(i));
        for (int i = 1; i < 5; i++) begin
            check("b2b_wb_gap",  wb_log[7+i].c - wb_log[6+i].c, 2);
            check("b2b_acc_gap", hold_acc[i] - hold_acc[i-1],   2);
        end

        // Illegal op: error pulse, no writeback, no register change.
        issue(4'd9, 3'd1, 3'd1, 3'd1, 1'b0, 8'h00, 0, rc);
        drain();
        check("ill_err_cnt", err_cnt,       1);
        check("ill_no_wb",   wb_log.size(), 12);
        peek(3'd1, 16'h000A, "ill_r1_kept");

        // Write to r0 still reports the computed value but is discarded.
        issue(4'd0, 3'd0, 3'd0, 3'd0, 1'b1, 8'h33, 0, rc);
        drain();
        check("r0_log_n", wb_log.size(),  13);
        check("r0_rd",    wb_log[12].rd,   3'd0);
        check("r0_data",  wb_log[12].data, 16'h0033);
        peek(3'd0, 16'h0000, "r0_dbg");

        // Reset during EXEC drops the instruction and clears the file.
        issue(4'd0, 3'd7, 3'd0, 3'd0, 1'b1, 8'h44, 0, rc);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        rc = cyc;
        issue(4'd0, 3'd2, 3'd0, 3'd0, 1'b1, 8'h01, 0, acc2);
        check("post_rst_accept", acc2, rc + 1);
        drain();
        check("rst_log_n", wb_log.size(), 14);
        check("rst_new_rd", wb_log[13].rd, 3'd2);
        peek(3'd7, 16'h0000, "rst_r7");
        peek(3'd1, 16'h0000, "rst_r1");
        peek(3'd2, 16'h0001, "rst_r2_new");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
